// File: rtl/mul_tile_engine.sv
// Output-stationary NxN multiply-accumulate tile: accumulates a_k (x) b_k into C,
// then drains C row by row with a streamed bias row added to each.

module mul_tile_row #(
    parameter int N         = 4,
    parameter int SUM_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         acc_en,
    input  logic [SUM_WIDTH-1:0]         a_elem,
    input  logic [N-1:0][SUM_WIDTH-1:0]  b_row,
    output logic [N-1:0][SUM_WIDTH-1:0]  c_row
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_row <= '0;
        end else if (clear) begin
            c_row <= '0;
        end else if (acc_en) begin
            for (int j = 0; j < N; j++)
                c_row[j] <= c_row[j] + a_elem * b_row[j];
        end
    end
endmodule

module mul_tile_engine #(
    parameter int SYSTOLIC_WIDTH = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int RIGHT_WIDTH    = 8,
    parameter int SUM_WIDTH      = 16,
    parameter int B_LANES        = 2,
    parameter int SIGNED_B       = 0,
    parameter int KLEN_WIDTH     = 16,
    localparam int N             = SYSTOLIC_WIDTH,
    localparam int LSEL_W        = (B_LANES > 1) ? $clog2(B_LANES) : 1,
    localparam int ROW_W         = (N > 1) ? $clog2(N) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             acc_clear,
    input  logic [KLEN_WIDTH-1:0]            k_len,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N*DATA_WIDTH-1:0]          a_data,
    input  logic [B_LANES*N*RIGHT_WIDTH-1:0] b_data,
    input  logic [LSEL_W-1:0]                b_lane_sel,
    input  logic                             bias_valid,
    output logic                             bias_ready,
    input  logic [N*SUM_WIDTH-1:0]           bias_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N*SUM_WIDTH-1:0]           out_data,
    output logic [ROW_W-1:0]                 out_row,
    output logic                             busy,
    output logic                             done
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t                                 state, state_nxt;
    logic [KLEN_WIDTH-1:0]                  k_len_q, beat_cnt;
    logic [ROW_W-1:0]                       row_cnt;
    logic                                   done_q;
    logic                                   beat, last_beat, row_fire, last_row, clear_c;

    logic [B_LANES-1:0][N-1:0][RIGHT_WIDTH-1:0] b_lanes;
    logic [N-1:0][RIGHT_WIDTH-1:0]              b_sel;
    logic [N-1:0][SUM_WIDTH-1:0]                a_ext, b_ext, bias_v, out_v;
    logic [N-1:0][N-1:0][SUM_WIDTH-1:0]         c_mat;

    assign b_lanes = b_data;
    assign bias_v  = bias_data;

    // Out-of-range lane selects fall back to lane 0.
    always_comb begin
        b_sel = b_lanes[0];
        if (int'(b_lane_sel) < B_LANES)
            b_sel = b_lanes[b_lane_sel];
    end

    for (genvar i = 0; i < N; i++) begin : g_ext
        if (SUM_WIDTH > DATA_WIDTH) begin : g_a_wide
            assign a_ext[i] = {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, a_data[i*DATA_WIDTH +: DATA_WIDTH]};
        end else begin : g_a_trunc
            assign a_ext[i] = a_data[i*DATA_WIDTH +: SUM_WIDTH];
        end
        if (SUM_WIDTH > RIGHT_WIDTH) begin : g_b_wide
            assign b_ext[i] = {{(SUM_WIDTH-RIGHT_WIDTH){(SIGNED_B != 0) && b_sel[i][RIGHT_WIDTH-1]}}, b_sel[i]};
        end else begin : g_b_trunc
            assign b_ext[i] = b_sel[i][SUM_WIDTH-1:0];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        mul_tile_row #(.N(N), .SUM_WIDTH(SUM_WIDTH)) u_row (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (clear_c),
            .acc_en (beat),
            .a_elem (a_ext[i]),
            .b_row  (b_ext),
            .c_row  (c_mat[i])
        );
    end

    assign beat      = in_valid && (state == LOAD);
    assign last_beat = beat && ((beat_cnt + KLEN_WIDTH'(1)) == k_len_q);
    assign row_fire  = out_valid && out_ready;
    assign last_row  = (row_cnt == ROW_W'(N-1));

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        bias_ready = 1'b0;
        clear_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear_c   = acc_clear;
                    state_nxt = (k_len != '0) ? LOAD : DRAIN;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (last_beat) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid  = bias_valid;
                bias_ready = out_ready;
                if (row_fire && last_row) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k_len_q  <= '0;
            beat_cnt <= '0;
            row_cnt  <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= row_fire && last_row;
            if (state == IDLE && start) k_len_q <= k_len;
            if (state != LOAD)  beat_cnt <= '0;
            else if (beat)      beat_cnt <= beat_cnt + KLEN_WIDTH'(1);
            if (state != DRAIN) row_cnt <= '0;
            else if (row_fire)  row_cnt <= row_cnt + ROW_W'(1);
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++)
            out_v[j] = c_mat[row_cnt][j] + bias_v[j];
    end

    assign out_data = out_v;
    assign out_row  = row_cnt;
    assign busy     = (state != IDLE);
    assign done     = done_q;
endmodule
